dmro_frame_aligner: RTL

DMRO_FRAME_ALIGNER -- requirements
Module: dmro_frame_aligner

---
 rtl/dmro_frame_aligner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmro_frame_aligner.sv
// dmro_frame_aligner: bit-serial DMRO frame aligner.
// Hunts for the 2'b10 header by slipping one bit per cycle. It then confirms
// the alignment over LOCK_THRESH consecutive frames. Once locked it emits every
// aligned 32-bit frame, flags bad headers, and drops lock after
// UNLOCK_THRESH consecutive bad headers.
module dmro_frame_aligner #(
    parameter int LOCK_THRESH   = 8,
    parameter int UNLOCK_THRESH = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        DataIn,
    input  logic        REVData,
    output logic [31:0] FrameOut,
    output logic        FrameValid,
    output logic        HeaderErr,
    output logic        Locked,
    output logic [15:0] ErrCnt
);

    localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int BAD_W  = $clog2(UNLOCK_THRESH + 1);

    // Compare against threshold-1 so the decision uses the pre-increment count.
    localparam logic [GOOD_W-1:0] GOOD_ONE    = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_THRESH - 1);
    localparam logic [BAD_W-1:0]  BAD_ONE     = BAD_W'(1);
    localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_THRESH - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } alignState;

    alignState         state;
    logic [30:0]       shiftReg;
    logic [4:0]        bitCnt;
    logic [GOOD_W-1:0] goodCnt;
    logic [BAD_W-1:0]  badCnt;

    logic [31:0] rawWord;
    logic [31:0] revWord;
    logic [31:0] candWord;
    logic        atBoundary;
    logic        headerGood;

    // The candidate word includes the bit arriving this cycle.
    // A frame is therefore judged on the same edge that samples its last bit.
    assign rawWord = {shiftReg, DataIn};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : gRev
            assign revWord[gi] = rawWord[31-gi];
        end
    endgenerate

    assign candWord   = REVData ? revWord : rawWord;
    assign atBoundary = (bitCnt == 5'd31);
    assign headerGood = (candWord[31:30] == 2'b10);

    // Alignment FSM with registered frame, strobe, lock and error outputs.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            shiftReg   <= '0;
            bitCnt     <= '0;
            goodCnt    <= '0;
            badCnt     <= '0;
            state      <= SEARCH;
            FrameOut   <= '0;
            FrameValid <= 1'b0;
            HeaderErr  <= 1'b0;
            Locked     <= 1'b0;
            ErrCnt     <= '0;
        end else begin
            shiftReg   <= rawWord[30:0];
            FrameValid <= 1'b0;
            HeaderErr  <= 1'b0;

            case (state)
                SEARCH: begin
                    // bitCnt parks at 31 while hunting.
                    // This makes every cycle a candidate position, one bit later each time.
                    if (!atBoundary) begin
                        bitCnt <= bitCnt + 5'd1;
                    end else if (headerGood) begin
                        state   <= CHECK;
                        goodCnt <= GOOD_ONE;
                        bitCnt  <= 5'd0;
                    end
                end

                CHECK: begin
                    if (!atBoundary) begin
                        bitCnt <= bitCnt + 5'd1;
                    end else if (headerGood) begin
                        bitCnt  <= 5'd0;
                        goodCnt <= goodCnt + GOOD_ONE;
                        if (goodCnt >= LOCK_LAST) begin
                            state  <= LOCKED;
                            Locked <= 1'b1;
                            badCnt <= '0;
                        end
                    end else begin
                        // False alignment: resume hunting on the very next bit.
                        state   <= SEARCH;
                        goodCnt <= '0;
                    end
                end

                LOCKED: begin
                    if (!atBoundary) begin
                        bitCnt <= bitCnt + 5'd1;
                    end else begin
                        FrameOut   <= candWord;
                        FrameValid <= 1'b1;
                        if (headerGood) begin
                            badCnt <= '0;
                            bitCnt <= 5'd0;
                        end else begin
                            HeaderErr <= 1'b1;
                            if (ErrCnt != 16'hFFFF) begin
                                ErrCnt <= ErrCnt + 16'd1;
                            end
                            if (badCnt >= UNLOCK_LAST) begin
                                // bitCnt stays at 31 so the hunt starts on the next bit.
                                state   <= SEARCH;
                                Locked  <= 1'b0;
                                badCnt  <= '0;
                                goodCnt <= '0;
                            end else begin
                                badCnt <= badCnt + BAD_ONE;
                                bitCnt <= 5'd0;
                            end
                        end
                    end
                end

                default: begin
                    state  <= SEARCH;
                    Locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
